// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: size codes, FSM states
// and the size-to-byte-mask helper.
// Pure declarations, no logic or state.
package lsu_pkg;

    // Request size codes carried in memop[1:0].
    localparam logic [1:0] SZ_B = 2'd3;  // 1 byte
    localparam logic [1:0] SZ_H = 2'd2;  // 2 bytes
    localparam logic [1:0] SZ_W = 2'd1;  // 4 bytes
    localparam logic [1:0] SZ_D = 2'd0;  // 8 bytes

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP,
        ERR
    } state_t;

    // Right-justified byte enables covering one access of the given size.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align_ext.sv
// Byte-lane alignment for the load/store controller, purely combinational.
// Latency: none. Backpressure: none (no handshake, no state).
// Store side: off/size/wdata -> two-word byte mask (mask2) and shifted data (wdata2).
// Load side : two-word read data {hi,lo} shifted down by off, truncated to
//             the access size, then sign- or zero-extended to DATA_W.
// Ports: off, size, sign_ext, wdata -> mask2, wdata2; rdata2 -> rdata.
module lsu_align_ext
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [OFF_W-1:0]    off,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/4-1:0] mask2,
    output logic [2*DATA_W-1:0] wdata2,
    input  logic [2*DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0]   rdata
);
    localparam int NB = DATA_W / 8;

    logic [OFF_W+2:0]  shamt;
    logic [DATA_W-1:0] win;
    logic [DATA_W-1:0] keep;
    logic              sbit;

    // Bit shift equivalent of the byte offset.
    assign shamt = {off, 3'b000};

    assign mask2  = (2*NB)'(size_mask(size)) << off;
    assign wdata2 = (2*DATA_W)'(wdata) << shamt;

    // Window of the two words starting at the addressed byte.
    assign win = DATA_W'(rdata2 >> shamt);

    always_comb begin
        keep = '1;
        sbit = 1'b0;
        case (size)
            SZ_B: begin
                keep = DATA_W'(8'hFF);
                sbit = win[7];
            end
            SZ_H: begin
                keep = DATA_W'(16'hFFFF);
                sbit = win[15];
            end
            SZ_W: begin
                keep = DATA_W'(32'hFFFF_FFFF);
                sbit = win[31];
            end
            default: begin
                keep = '1;
                sbit = 1'b0;
            end
        endcase
    end

    // Bits above the access size are either cleared or filled with the sign.
    assign rdata = (win & keep) | ((sign_ext && sbit) ? ~keep : '0);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequential load/store controller: one request in, one or two aligned word beats out, one response back.
// Latency with zero-wait memory: response 3 cycles after accept (unsplit), 5 (split), 1 (no-op/error).
// Backpressure: req_ready only in IDLE; mem_* held until mem_req_ready; rsp_* held until rsp_ready.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/ready/addr/memop/wen/wdata   request from the core memory stage
//   rsp_valid/ready/rdata/err         response to the core
//   mem_req_valid/ready, mem_addr/wen/wdata/wmask   beat request to the bus bridge
//   mem_rsp_valid, mem_rdata          one-cycle beat response (read data or write ack)
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2:0]          req_memop,
    input  logic                req_wen,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    state_t             state;

    // Registered request context.
    logic [OFF_W-1:0]   off_q;
    logic [ADDR_W-1:0]  base_q;
    logic [2:0]         memop_q;
    logic               wen_q;
    logic               split_q;
    logic [NB-1:0]      mask_hi_q;
    logic [DATA_W-1:0]  wdata_hi_q;
    logic [DATA_W-1:0]  lo_q;

    // Store-side alignment of the incoming request.
    logic [2*NB-1:0]     st_mask2;
    logic [2*DATA_W-1:0] st_wdata2;
    logic [DATA_W-1:0]   unused_st_rdata;

    // Load-side alignment of the returned words.
    logic [2*NB-1:0]     unused_ld_mask2;
    logic [2*DATA_W-1:0] unused_ld_wdata2;
    logic [DATA_W-1:0]   ld_rdata;
    logic [DATA_W-1:0]   ld_lo;
    logic [DATA_W-1:0]   ld_hi;

    logic                req_illegal;
    logic                req_noop;
    logic [ADDR_W-1:0]   req_base;

    assign req_ready   = (state == IDLE) && !rst;
    assign req_illegal = (DATA_W == 32) && (req_memop[1:0] == SZ_D);
    assign req_noop    = (req_memop == 3'b000) && !req_wen;
    assign req_base    = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    lsu_align_ext #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_st_align (
        .off      (req_addr[OFF_W-1:0]),
        .size     (req_memop[1:0]),
        .sign_ext (req_memop[2]),
        .wdata    (req_wdata),
        .mask2    (st_mask2),
        .wdata2   (st_wdata2),
        .rdata2   ('0),
        .rdata    (unused_st_rdata)
    );

    // The load result is computed from the beat arriving this cycle so the
    // response can be registered in the same edge that ends the last wait.
    // An unsplit access sees zero in the upper word.
    always_comb begin
        ld_lo = lo_q;
        ld_hi = '0;
        if (state == WAIT0) begin
            ld_lo = mem_rdata;
        end
        if (state == WAIT1) begin
            ld_hi = mem_rdata;
        end
    end

    lsu_align_ext #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_ld_align (
        .off      (off_q),
        .size     (memop_q[1:0]),
        .sign_ext (memop_q[2]),
        .wdata    ('0),
        .mask2    (unused_ld_mask2),
        .wdata2   (unused_ld_wdata2),
        .rdata2   ({ld_hi, ld_lo}),
        .rdata    (ld_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            off_q         <= '0;
            base_q        <= '0;
            memop_q       <= '0;
            wen_q         <= 1'b0;
            split_q       <= 1'b0;
            mask_hi_q     <= '0;
            wdata_hi_q    <= '0;
            lo_q          <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        off_q      <= req_addr[OFF_W-1:0];
                        base_q     <= req_base;
                        memop_q    <= req_memop;
                        wen_q      <= req_wen;
                        split_q    <= |st_mask2[2*NB-1:NB];
                        mask_hi_q  <= st_mask2[2*NB-1:NB];
                        wdata_hi_q <= st_wdata2[2*DATA_W-1:DATA_W];
                        if (req_illegal) begin
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_noop) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else begin
                            state         <= REQ0;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= req_base;
                            mem_wen       <= req_wen;
                            mem_wmask     <= st_mask2[NB-1:0];
                            mem_wdata     <= st_wdata2[DATA_W-1:0];
                        end
                    end
                end

                REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT0;
                    end
                end

                WAIT0: begin
                    if (mem_rsp_valid) begin
                        lo_q <= mem_rdata;
                        if (split_q) begin
                            state         <= REQ1;
                            mem_req_valid <= 1'b1;
                            // Wraps modulo 2^ADDR_W at the top of the address space.
                            mem_addr      <= base_q + ADDR_W'(NB);
                            mem_wmask     <= mask_hi_q;
                            mem_wdata     <= wdata_hi_q;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= wen_q ? '0 : ld_rdata;
                        end
                    end
                end

                REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT1;
                    end
                end

                WAIT1: begin
                    if (mem_rsp_valid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= wen_q ? '0 : ld_rdata;
                    end
                end

                RESP, ERR: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a 64-bit instance against a small memory
// model with optional beat stalls, plus a 32-bit instance for the illegal-size path.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 64-bit instance
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [2:0]  req_memop = '0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;

    // 32-bit instance
    logic        req_valid_32 = 1'b0;
    logic        req_ready_32;
    logic [31:0] req_addr_32 = '0;
    logic [2:0]  req_memop_32 = '0;
    logic        req_wen_32 = 1'b0;
    logic [31:0] req_wdata_32 = '0;
    logic        rsp_valid_32;
    logic        rsp_ready_32 = 1'b0;
    logic [31:0] rsp_rdata_32;
    logic        rsp_err_32;
    logic        mem_req_valid_32;
    logic        mem_req_ready_32 = 1'b1;
    logic [31:0] mem_addr_32;
    logic        mem_wen_32;
    logic [31:0] mem_wdata_32;
    logic [3:0]  mem_wmask_32;
    logic        mem_rsp_valid_32 = 1'b0;
    logic [31:0] mem_rdata_32 = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DATA_W(64), .ADDR_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_memop     (req_memop),
        .req_wen       (req_wen),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid_32),
        .req_ready     (req_ready_32),
        .req_addr      (req_addr_32),
        .req_memop     (req_memop_32),
        .req_wen       (req_wen_32),
        .req_wdata     (req_wdata_32),
        .rsp_valid     (rsp_valid_32),
        .rsp_ready     (rsp_ready_32),
        .rsp_rdata     (rsp_rdata_32),
        .rsp_err       (rsp_err_32),
        .mem_req_valid (mem_req_valid_32),
        .mem_req_ready (mem_req_ready_32),
        .mem_addr      (mem_addr_32),
        .mem_wen       (mem_wen_32),
        .mem_wdata     (mem_wdata_32),
        .mem_wmask     (mem_wmask_32),
        .mem_rsp_valid (mem_rsp_valid_32),
        .mem_rdata     (mem_rdata_32)
    );

    // ---------------- memory model for the 64-bit instance ----------------
    // Decides ready at each falling edge; a beat accepted on the next rising
    // edge is answered during the following cycle.
    logic [63:0] mem [logic [63:0]];
    logic [63:0] b_addr [$];
    logic [7:0]  b_mask [$];
    logic [63:0] b_wdata [$];
    logic        b_wen [$];
    int          beat_cnt   = 0;
    int          stall_arm  = 0;   // written by tests
    int          stall_used = 0;   // written by model
    int          drop_from  = 1 << 30;
    int          stale_tok  = 0;
    int          stale_used = 0;
    logic        pend = 1'b0;
    int          pend_idx = 0;
    logic [63:0] pend_data = '0;
    logic        seen32 = 1'b0;

    always @(negedge clk) begin
        logic [63:0] w;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            pend = 1'b0;
            if (pend_idx < drop_from) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = pend_data;
            end
        end else if (stale_used != stale_tok) begin
            stale_used++;
            mem_rsp_valid = 1'b1;
            mem_rdata     = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        if (mem_req_valid && !rst && stall_used < stall_arm) begin
            stall_used++;
            mem_req_ready = 1'b0;
        end else begin
            mem_req_ready = 1'b1;
            if (mem_req_valid && !rst) begin
                b_addr.push_back(mem_addr);
                b_mask.push_back(mem_wmask);
                b_wdata.push_back(mem_wdata);
                b_wen.push_back(mem_wen);
                w = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
                pend_data = w;
                if (mem_wen) begin
                    for (int i = 0; i < 8; i++)
                        if (mem_wmask[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                    mem[mem_addr] = w;
                end
                pend     = 1'b1;
                pend_idx = beat_cnt;
                beat_cnt++;
            end
        end
        if (mem_req_valid_32) seen32 = 1'b1;
    end

    // Drives one request on the 64-bit instance, waits for the response and
    // takes it. lat counts cycles from the accept cycle; -1 means no response.
    task automatic issue64(input logic [63:0] a, input logic [2:0] op, input logic w,
                           input logic [63:0] wd, output int lat,
                           output logic [63:0] rd, output logic er);
        @(negedge clk);
        req_addr  = a;
        req_memop = op;
        req_wen   = w;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready_in_rst: got %b want 0", req_ready); end
        total++; if (req_ready_32 !== 1'b0) begin bad++; $display("FAIL reset_req_ready32_in_rst: got %b want 0", req_ready_32); end
        total++; if ({rsp_valid, rsp_err, mem_req_valid, mem_wen} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_err, mem_req_valid, mem_wen}); end
        total++; if ({rsp_rdata, mem_addr, mem_wdata, mem_wmask} !== '0) begin bad++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h mask=%h want 0", rsp_rdata, mem_addr, mem_wdata, mem_wmask); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready_after: got %b want 1", req_ready); end
    endtask

    task automatic test_aligned();
        int lat; logic [63:0] rd; logic er; int b0;
        b0 = beat_cnt;
        issue64(64'h8000_0000, 3'b000, 1'b1, 64'h1122_3344_5566_7788, lat, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL aligned_store_lat: got %0d want 3", lat); end
        total++; if (beat_cnt - b0 !== 1) begin bad++; $display("FAIL aligned_store_beats: got %0d want 1", beat_cnt - b0); end
        total++; if (b_addr[b0] !== 64'h8000_0000 || b_mask[b0] !== 8'hFF || b_wen[b0] !== 1'b1) begin bad++; $display("FAIL aligned_store_beat: got addr=%h mask=%h wen=%b want 80000000 ff 1", b_addr[b0], b_mask[b0], b_wen[b0]); end
        total++; if (b_wdata[b0] !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL aligned_store_wdata: got %h want 1122334455667788", b_wdata[b0]); end
        total++; if (rd !== 64'h0 || er !== 1'b0) begin bad++; $display("FAIL aligned_store_rsp: got rdata=%h err=%b want 0 0", rd, er); end
        issue64(64'h8000_0000, 3'b100, 1'b0, 64'h0, lat, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL aligned_load_lat: got %0d want 3", lat); end
        total++; if (rd !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL aligned_load_data: got %h want 1122334455667788", rd); end
    endtask

    task automatic test_byte_load();
        int lat; logic [63:0] rd; logic er; int b0;
        issue64(64'h8000_0000, 3'b000, 1'b1, 64'h0000_0000_8000_0000, lat, rd, er);
        b0 = beat_cnt;
        issue64(64'h8000_0003, 3'b111, 1'b0, 64'h0, lat, rd, er);
        total++; if (rd !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL byte_load_signed: got %h want ffffffffffffff80", rd); end
        total++; if (b_addr[b0] !== 64'h8000_0000 || b_mask[b0] !== 8'h08) begin bad++; $display("FAIL byte_load_beat: got addr=%h mask=%h want 80000000 08", b_addr[b0], b_mask[b0]); end
        issue64(64'h8000_0003, 3'b011, 1'b0, 64'h0, lat, rd, er);
        total++; if (rd !== 64'h80) begin bad++; $display("FAIL byte_load_unsigned: got %h want 80", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL byte_load_lat: got %0d want 3", lat); end
    endtask

    task automatic test_misaligned();
        int lat; logic [63:0] rd; logic er; int b0;
        b0 = beat_cnt;
        issue64(64'h8000_0006, 3'b001, 1'b1, 64'hAABB_CCDD, lat, rd, er);
        total++; if (beat_cnt - b0 !== 2) begin bad++; $display("FAIL split_store_beats: got %0d want 2", beat_cnt - b0); end
        total++; if (b_addr[b0] !== 64'h8000_0000 || b_mask[b0] !== 8'hC0 || b_wdata[b0][63:48] !== 16'hCCDD) begin bad++; $display("FAIL split_store_beat0: got addr=%h mask=%h wd=%h want 80000000 c0 ccdd", b_addr[b0], b_mask[b0], b_wdata[b0][63:48]); end
        total++; if (b_addr[b0+1] !== 64'h8000_0008 || b_mask[b0+1] !== 8'h03 || b_wdata[b0+1][15:0] !== 16'hAABB) begin bad++; $display("FAIL split_store_beat1: got addr=%h mask=%h wd=%h want 80000008 03 aabb", b_addr[b0+1], b_mask[b0+1], b_wdata[b0+1][15:0]); end
        total++; if (lat !== 5) begin bad++; $display("FAIL split_store_lat: got %0d want 5", lat); end
        issue64(64'h8000_0006, 3'b101, 1'b0, 64'h0, lat, rd, er);
        total++; if (rd !== 64'hFFFF_FFFF_AABB_CCDD) begin bad++; $display("FAIL split_load_signed: got %h want ffffffffaabbccdd", rd); end
        total++; if (lat !== 5) begin bad++; $display("FAIL split_load_lat: got %0d want 5", lat); end
        issue64(64'h8000_0006, 3'b001, 1'b0, 64'h0, lat, rd, er);
        total++; if (rd !== 64'h0000_0000_AABB_CCDD) begin bad++; $display("FAIL split_load_unsigned: got %h want aabbccdd", rd); end
    endtask

    task automatic test_backpressure();
        int b0; int lat;
        b0 = beat_cnt;
        stall_arm = stall_used + 3;
        @(negedge clk);
        req_addr  = 64'h8000_0000;
        req_memop = 3'b100;
        req_wen   = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_wmask !== 8'hFF || mem_wen !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_mem_hold%0d: got vld=%b addr=%h mask=%h wen=%b rdy=%b want 1 80000000 ff 0 0", c, mem_req_valid, mem_addr, mem_wmask, mem_wen, req_ready);
            end
            @(negedge clk);
        end
        lat = 4;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 6) begin bad++; $display("FAIL bp_lat: got %0d want 6", lat); end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hCCDD_0000_8000_0000 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_rsp_hold%0d: got vld=%b rdata=%h err=%b rdy=%b want 1 ccdd000080000000 0 0", c, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            if (c < 2) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready); end
        total++; if (beat_cnt - b0 !== 1) begin bad++; $display("FAIL bp_beats: got %0d want 1", beat_cnt - b0); end
    endtask

    task automatic test_reset_mid();
        int b0; int lat; logic [63:0] rd; logic er;
        b0 = beat_cnt;
        drop_from = beat_cnt + 1;
        @(negedge clk);
        req_addr  = 64'h8000_0006;
        req_memop = 3'b101;
        req_wen   = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (beat_cnt - b0 !== 2 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_before: got beats=%0d vld=%b want 2 0", beat_cnt - b0, rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drop_from = 1 << 30;
        total++; if (rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_after: got rsp=%b mem=%b want 0 0", rsp_valid, mem_req_valid); end
        @(negedge clk);
        stale_tok++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_idle%0d: got rsp=%b mem=%b rdy=%b want 0 0 1", c, rsp_valid, mem_req_valid, req_ready);
            end
        end
        total++; if (beat_cnt - b0 !== 2) begin bad++; $display("FAIL rstmid_beats: got %0d want 2", beat_cnt - b0); end
        issue64(64'h8000_0000, 3'b100, 1'b0, 64'h0, lat, rd, er);
        total++; if (rd !== 64'hCCDD_0000_8000_0000 || lat !== 3) begin bad++; $display("FAIL rstmid_next_load: got %h lat=%0d want ccdd000080000000 lat=3", rd, lat); end
    endtask

    task automatic test_noop();
        int b0; int lat; logic [63:0] rd; logic er;
        b0 = beat_cnt;
        issue64(64'h8000_0010, 3'b000, 1'b0, 64'hFFFF, lat, rd, er);
        total++; if (lat !== 1) begin bad++; $display("FAIL noop_lat: got %0d want 1", lat); end
        total++; if (rd !== 64'h0 || er !== 1'b0) begin bad++; $display("FAIL noop_rsp: got rdata=%h err=%b want 0 0", rd, er); end
        total++; if (beat_cnt - b0 !== 0) begin bad++; $display("FAIL noop_beats: got %0d want 0", beat_cnt - b0); end
    endtask

    task automatic test_err32();
        logic [2:0] ops [2];
        logic       wens [2];
        ops[0] = 3'b100; wens[0] = 1'b0;
        ops[1] = 3'b000; wens[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_addr_32  = 32'h0000_1000;
            req_memop_32 = ops[k];
            req_wen_32   = wens[k];
            req_wdata_32 = 32'h1234_5678;
            req_valid_32 = 1'b1;
            @(negedge clk);
            req_valid_32 = 1'b0;
            total++;
            if (rsp_valid_32 !== 1'b1 || rsp_err_32 !== 1'b1 || rsp_rdata_32 !== 32'h0) begin
                bad++;
                $display("FAIL err32_%0d: got vld=%b err=%b rdata=%h want 1 1 0", k, rsp_valid_32, rsp_err_32, rsp_rdata_32);
            end
            rsp_ready_32 = 1'b1;
            @(negedge clk);
            rsp_ready_32 = 1'b0;
            total++;
            if (rsp_valid_32 !== 1'b0 || rsp_err_32 !== 1'b0 || req_ready_32 !== 1'b1) begin
                bad++;
                $display("FAIL err32_release%0d: got vld=%b err=%b rdy=%b want 0 0 1", k, rsp_valid_32, rsp_err_32, req_ready_32);
            end
        end
        total++; if (seen32 !== 1'b0) begin bad++; $display("FAIL err32_no_beat: got %b want 0", seen32); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_byte_load();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        test_noop();
        test_err32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
